// File: rtl/clk_div_prog_multi.sv
// Multi-channel programmable clock divider.
// Each channel produces a near-50% duty divided clock and a one-cycle tick at
// every rising edge of that clock. Divisor changes are shadowed and only take
// effect at a period boundary, in IDLE, or on a sync restart, so no short pulse
// is ever emitted.
module clk_div_prog_multi #(
    parameter int unsigned CH      = 4,
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned DIV_RST = 6
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic [CH-1:0]       en,
    input  logic [CH-1:0]       div_load,
    input  logic [CH*DIV_W-1:0] div_in,
    input  logic                sync,
    output logic [CH-1:0]       clk_out,
    output logic [CH-1:0]       tick,
    output logic [CH-1:0]       active
);

    typedef enum logic {StIdle, StRun} state_e;

    localparam logic [DIV_W-1:0] DivRst = DIV_W'(DIV_RST);
    localparam logic [DIV_W-1:0] DivOne = DIV_W'(1);
    localparam logic [DIV_W-1:0] DivTwo = DIV_W'(2);

    for (genvar i = 0; i < CH; i++) begin : g_ch
        state_e           state_q, state_d;
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [DIV_W-1:0] div_act_q, div_act_d;
        logic [DIV_W-1:0] pend_q, pend_d;
        logic             pend_vld_q, pend_vld_d;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;

        logic [DIV_W-1:0] div_slice, div_nxt, div_eff, half, cnt_inc;
        logic             apply_req, boundary, restart, eff_ok;

        // Divisor selection and period arithmetic for this channel.
        always_comb begin
            div_slice = div_in[i*DIV_W +: DIV_W];
            // A load on this very edge wins over an older pending value.
            div_nxt   = div_load[i] ? div_slice : pend_q;
            apply_req = pend_vld_q | div_load[i];
            div_eff   = apply_req ? div_nxt : div_act_q;
            eff_ok    = (div_eff >= DivTwo);
            half      = (div_act_q >> 1) + DIV_W'(div_act_q[0]);
            cnt_inc   = cnt_q + DivOne;
            boundary  = (cnt_q == div_act_q - DivOne);
            // sync and a natural boundary on the same edge collapse into one restart.
            restart   = (state_q == StRun) && (boundary || sync);
        end

        // Next-state logic: shadow divisor handling plus the IDLE/RUN machine.
        always_comb begin
            state_d    = state_q;
            cnt_d      = cnt_q;
            clk_d      = clk_q;
            tick_d     = 1'b0;
            div_act_d  = div_act_q;
            pend_d     = pend_q;
            pend_vld_d = pend_vld_q;

            if (div_load[i]) begin
                pend_d     = div_slice;
                pend_vld_d = 1'b1;
            end
            if (apply_req && ((state_q == StIdle) || restart)) begin
                div_act_d  = div_nxt;
                pend_vld_d = 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    cnt_d = '0;
                    clk_d = 1'b0;
                    if (en[i] && eff_ok) begin
                        state_d = StRun;
                        clk_d   = 1'b1;
                        tick_d  = 1'b1;
                    end
                end
                StRun: begin
                    if (restart) begin
                        cnt_d = '0;
                        if (!en[i] || !eff_ok) begin
                            state_d = StIdle;
                            clk_d   = 1'b0;
                        end else begin
                            clk_d  = 1'b1;
                            tick_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                        clk_d = (cnt_inc < half);
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Channel state register with asynchronous reset.
        always_ff @(posedge clk_in or posedge reset) begin
            if (reset) begin
                state_q    <= StIdle;
                cnt_q      <= '0;
                div_act_q  <= DivRst;
                pend_q     <= '0;
                pend_vld_q <= 1'b0;
                clk_q      <= 1'b0;
                tick_q     <= 1'b0;
            end else begin
                state_q    <= state_d;
                cnt_q      <= cnt_d;
                div_act_q  <= div_act_d;
                pend_q     <= pend_d;
                pend_vld_q <= pend_vld_d;
                clk_q      <= clk_d;
                tick_q     <= tick_d;
            end
        end

        assign clk_out[i] = clk_q;
        assign tick[i]    = tick_q;
        assign active[i]  = (state_q == StRun);
    end

endmodule
